// File: rtl/nco_cfg_arbiter_if.sv
// Requester and NCO configuration bus bundle for nco_cfg_arbiter.
// slave = arbiter side, master = requesters plus NCO side.
interface nco_cfg_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTL_WIDTH  = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [2*NUM_REQ-1:0]          req_cmd;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic                          rsp_err;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic [DATA_WIDTH-1:0]         nco_freq_mod;
  logic [DATA_WIDTH-1:0]         nco_pha_mod;
  logic [CTL_WIDTH-1:0]          nco_ctl;
  logic                          nco_ack;
  logic                          nco_done;
  logic [DATA_WIDTH-1:0]         nco_cur_pha;

  modport master (
    output req_valid, req_cmd, req_data, nco_ack, nco_done, nco_cur_pha,
    input  req_ready, rsp_valid, rsp_err, rsp_data, nco_freq_mod, nco_pha_mod, nco_ctl
  );

  modport slave (
    input  req_valid, req_cmd, req_data, nco_ack, nco_done, nco_cur_pha,
    output req_ready, rsp_valid, rsp_err, rsp_data, nco_freq_mod, nco_pha_mod, nco_ctl
  );
endinterface

// File: rtl/nco_cfg_arbiter.sv
// Round-robin arbiter sharing the single NCO configuration port among NUM_REQ
// requesters. One command in flight, per-phase timeout, phase readback routed
// back to the issuing requester.
module nco_cfg_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTL_WIDTH  = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  CLK,
  input  logic                  nRST,
  nco_cfg_arbiter_if.slave      bus,
  output logic                  busy,
  output logic [7:0]            err_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] RESP      = 2'd3;

  localparam logic [1:0] CMD_SET_FREQ   = 2'd0;
  localparam logic [1:0] CMD_ADD_PHASE  = 2'd1;
  localparam logic [1:0] CMD_LOAD_PHASE = 2'd2;
  localparam logic [1:0] CMD_READ_PHASE = 2'd3;

  // Timer starts at 0 on entry, so TIMEOUT waiting cycles end at TIMEOUT-1.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  logic [1:0]            state;
  logic [IDX_W-1:0]      rrPtr;
  logic [IDX_W-1:0]      grantIdx;
  logic [1:0]            cmdReg;
  logic [7:0]            timer;
  logic [CTL_WIDTH-1:0]  ctlReg;
  logic [DATA_WIDTH-1:0] freqModReg;
  logic [DATA_WIDTH-1:0] phaModReg;
  logic [NUM_REQ-1:0]    rspValidReg;
  logic                  rspErrReg;
  logic [DATA_WIDTH-1:0] rspDataReg;
  logic [7:0]            errCntReg;

  logic                  pickValid;
  logic [IDX_W-1:0]      pickIdx;
  logic [IDX_W-1:0]      rrNext;
  logic [1:0]            pickCmd;
  logic [DATA_WIDTH-1:0] pickData;
  logic [NUM_REQ-1:0]    reqReady;
  logic                  timerExpired;
  logic                  finishOk;
  logic                  finishErr;

  function automatic logic [IDX_W-1:0] wrapIdx(input int unsigned v);
    return IDX_W'((v >= NUM_REQ) ? (v - NUM_REQ) : v);
  endfunction

  // Pick the first pending requester at or after the round-robin pointer.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pickValid && bus.req_valid[wrapIdx(32'(rrPtr) + i)]) begin
        pickValid = 1'b1;
        pickIdx   = wrapIdx(32'(rrPtr) + i);
      end
    end
  end

  assign pickCmd  = bus.req_cmd[2*pickIdx +: 2];
  assign pickData = bus.req_data[DATA_WIDTH*pickIdx +: DATA_WIDTH];
  assign rrNext   = (pickIdx == IDX_W'(NUM_REQ - 1)) ? '0 : pickIdx + 1'b1;

  // Accept pulse only while idle, towards the chosen requester.
  always_comb begin
    reqReady = '0;
    if (state == IDLE && pickValid) begin
      reqReady[pickIdx] = 1'b1;
    end
  end

  assign timerExpired = (timer == TIMER_LAST);

  // ACK together with DONE in ISSUE counts as a completed command.
  assign finishOk  = (state == ISSUE     && bus.nco_ack && bus.nco_done) ||
                     (state == WAIT_DONE && bus.nco_done);
  assign finishErr = (state == ISSUE     && !bus.nco_ack  && timerExpired) ||
                     (state == WAIT_DONE && !bus.nco_done && timerExpired);

  // Command FSM: grant, drive NCO ctl/operands, wait for ACK then DONE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      rrPtr      <= '0;
      grantIdx   <= '0;
      cmdReg     <= CMD_SET_FREQ;
      timer      <= '0;
      ctlReg     <= '0;
      freqModReg <= '0;
      phaModReg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pickValid) begin
            grantIdx <= pickIdx;
            cmdReg   <= pickCmd;
            rrPtr    <= rrNext;
            timer    <= '0;
            ctlReg   <= CTL_WIDTH'(1) << pickCmd;
            if (pickCmd == CMD_SET_FREQ) begin
              freqModReg <= pickData;
            end
            if (pickCmd == CMD_ADD_PHASE || pickCmd == CMD_LOAD_PHASE) begin
              phaModReg <= pickData;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.nco_ack) begin
            ctlReg <= '0;
            timer  <= '0;
            state  <= bus.nco_done ? RESP : WAIT_DONE;
          end else if (timerExpired) begin
            ctlReg <= '0;
            state  <= RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (bus.nco_done || timerExpired) begin
            state <= RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion pulse, held result/error and saturating timeout counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rspValidReg <= '0;
      rspErrReg   <= 1'b0;
      rspDataReg  <= '0;
      errCntReg   <= '0;
    end else begin
      rspValidReg <= '0;
      if (finishOk) begin
        rspValidReg <= NUM_REQ'(1) << grantIdx;
        rspErrReg   <= 1'b0;
        rspDataReg  <= (cmdReg == CMD_READ_PHASE) ? bus.nco_cur_pha : '0;
      end else if (finishErr) begin
        rspValidReg <= NUM_REQ'(1) << grantIdx;
        rspErrReg   <= 1'b1;
        rspDataReg  <= '0;
        if (errCntReg != 8'hFF) begin
          errCntReg <= errCntReg + 8'd1;
        end
      end
    end
  end

  assign bus.req_ready    = reqReady;
  assign bus.rsp_valid    = rspValidReg;
  assign bus.rsp_err      = rspErrReg;
  assign bus.rsp_data     = rspDataReg;
  assign bus.nco_freq_mod = freqModReg;
  assign bus.nco_pha_mod  = phaModReg;
  assign bus.nco_ctl      = ctlReg;
  assign busy             = (state != IDLE);
  assign err_cnt          = errCntReg;

endmodule

// File: tb/tb_nco_cfg_arbiter.sv
// Bench for nco_cfg_arbiter: queued requesters, a behavioural NCO, and a
// scoreboard fed at grant time and drained by a response monitor.
module tb_nco_cfg_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int TO = 31;

  typedef struct {
    logic [1:0]    cmd;
    logic [DW-1:0] data;
  } req_t;

  typedef struct {
    int            idx;
    logic          err;
    logic [DW-1:0] data;
    logic [DW-1:0] fpin;
    logic [DW-1:0] ppin;
    int            ecnt;
    int            lat;
    int            ctlCyc;
  } rsp_t;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       busy;
  logic [7:0] err_cnt;

  always #5 CLK = ~CLK;

  nco_cfg_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CTL_WIDTH(CW)) bus ();

  nco_cfg_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .CTL_WIDTH(CW), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus), .busy(busy), .err_cnt(err_cnt)
  );

  int tests = 0;
  int fails = 0;
  longint cyc = 0;
  int mode = 0;          // 0 normal NCO, 1 never ACK, 2 ACK without DONE
  int rspSeen = 0;

  req_t dq[NR][$];       // driver queues (what requesters present)
  req_t mq[NR][$];       // model copies of pending requests
  rsp_t rspQ[$];
  longint grantLog[$];
  int     grantIdxLog[$];

  int            mRr = 0;
  int            mErr = 0;
  logic [DW-1:0] mFreqPin = '0;
  logic [DW-1:0] mPhaPin = '0;
  logic [DW-1:0] mPhase = '0;

  logic [DW-1:0] ncoFreq = '0;
  logic [DW-1:0] ncoPhase = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input int i, input logic [1:0] cmd, input logic [DW-1:0] data);
    req_t r;
    r.cmd = cmd;
    r.data = data;
    dq[i].push_back(r);
    mq[i].push_back(r);
  endtask

  function automatic int predictGrant();
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (mRr + k) % NR;
      if (mq[i].size() > 0) return i;
    end
    return -1;
  endfunction

  // Requesters: present queue heads, pop an entry once its accept pulse was seen.
  initial begin
    logic [NR-1:0]    acc;
    logic [NR-1:0]    v;
    logic [2*NR-1:0]  c;
    logic [DW*NR-1:0] d;
    bus.req_valid = '0;
    bus.req_cmd = '0;
    bus.req_data = '0;
    forever begin
      @(negedge CLK);
      acc = nRST ? bus.req_ready : '0;
      @(posedge CLK);
      #1;
      v = '0; c = '0; d = '0;
      for (int i = 0; i < NR; i++) begin
        if (acc[i] && dq[i].size() > 0) void'(dq[i].pop_front());
        if (dq[i].size() > 0) begin
          v[i] = 1'b1;
          c[2*i +: 2] = dq[i][0].cmd;
          d[DW*i +: DW] = dq[i][0].data;
        end
      end
      bus.req_valid = v;
      bus.req_cmd = c;
      bus.req_data = d;
    end
  end

  // Behavioural NCO: ACK one cycle after ctl, DONE one after ACK, plus stray pulses when quiet.
  initial begin
    int stage;
    int r;
    logic [CW-1:0] lctl;
    stage = 0;
    lctl = '0;
    bus.nco_ack = 1'b0;
    bus.nco_done = 1'b0;
    bus.nco_cur_pha = '0;
    forever begin
      @(posedge CLK);
      #1;
      bus.nco_ack = 1'b0;
      bus.nco_done = 1'b0;
      bus.nco_cur_pha = $urandom;
      if (!nRST) stage = 0;
      r = $urandom_range(0, 7);
      case (stage)
        0: begin
          if (bus.nco_ctl != 0 && mode != 1) begin
            lctl = bus.nco_ctl;
            stage = 1;
          end else if (mode == 0 && bus.nco_ctl == 0) begin
            bus.nco_ack = (r == 0 || r == 2);
            bus.nco_done = (r == 1 || r == 2);
          end
        end
        1: begin
          bus.nco_ack = 1'b1;
          stage = (mode == 0) ? 2 : 0;
        end
        2: begin
          bus.nco_done = 1'b1;
          case (lctl)
            4'b0001: ncoFreq = bus.nco_freq_mod;
            4'b0010: ncoPhase = ncoPhase + bus.nco_pha_mod;
            4'b0100: ncoPhase = bus.nco_pha_mod;
            4'b1000: bus.nco_cur_pha = ncoPhase;
            default: ;
          endcase
          stage = 3;
        end
        default: begin
          bus.nco_ack = (r == 0);
          bus.nco_done = (r == 1);
          stage = 0;
        end
      endcase
    end
  end

  // Monitor: predict on each grant, compare on each response.
  initial begin
    int            g;
    int            ctlCount;
    bit            ctlBad;
    logic [CW-1:0] expCtl;
    longint        gCyc;
    bit            holdChk;
    logic [DW-1:0] lastData;
    logic          lastErr;
    req_t          r;
    rsp_t          e;
    ctlCount = 0; ctlBad = 0; expCtl = '0; gCyc = 0;
    holdChk = 0; lastData = '0; lastErr = 0;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        ctlCount = 0; ctlBad = 0; holdChk = 0; lastData = '0; lastErr = 0;
        continue;
      end
      if (holdChk) begin
        check("rsp_data_hold", bus.rsp_data, lastData);
        check("rsp_err_hold", bus.rsp_err, lastErr);
        holdChk = 0;
      end
      if (bus.req_ready != 0) begin
        g = predictGrant();
        if (g < 0) begin
          check("grant_unexpected", bus.req_ready, 0);
        end else begin
          check("grant", bus.req_ready, 64'(NR'(1) << g));
          r = mq[g].pop_front();
          mRr = (g + 1) % NR;
          if (r.cmd == 2'd0) mFreqPin = r.data;
          if (r.cmd == 2'd1 || r.cmd == 2'd2) mPhaPin = r.data;
          e.idx = g; e.fpin = mFreqPin; e.ppin = mPhaPin; e.data = '0;
          if (mode == 0) begin
            e.err = 0; e.lat = 4; e.ctlCyc = 2;
            case (r.cmd)
              2'd1: mPhase = mPhase + r.data;
              2'd2: mPhase = r.data;
              2'd3: e.data = mPhase;
              default: ;
            endcase
          end else begin
            e.err = 1;
            e.lat = (mode == 1) ? TO + 1 : TO + 3;
            e.ctlCyc = (mode == 1) ? TO : 2;
            if (mErr < 255) mErr++;
          end
          e.ecnt = mErr;
          rspQ.push_back(e);
          expCtl = CW'(1) << r.cmd;
          gCyc = cyc;
          ctlCount = 0;
          ctlBad = 0;
          grantLog.push_back(cyc);
          grantIdxLog.push_back(g);
        end
      end
      if (bus.nco_ctl != 0) begin
        ctlCount++;
        if (bus.nco_ctl !== expCtl) ctlBad = 1;
      end
      if (bus.rsp_valid != 0) begin
        rspSeen++;
        if (rspQ.size() == 0) begin
          check("rsp_unexpected", bus.rsp_valid, 0);
        end else begin
          e = rspQ.pop_front();
          check("rsp_valid", bus.rsp_valid, 64'(NR'(1) << e.idx));
          check("rsp_err", bus.rsp_err, e.err);
          check("rsp_data", bus.rsp_data, e.data);
          check("freq_mod", bus.nco_freq_mod, e.fpin);
          check("pha_mod", bus.nco_pha_mod, e.ppin);
          check("err_cnt", err_cnt, 64'(e.ecnt));
          check("latency", 64'(cyc - gCyc), 64'(e.lat));
          check("ctl_cycles", 64'(ctlCount), 64'(e.ctlCyc));
          check("ctl_value", 64'(ctlBad), 0);
          lastData = e.data;
          lastErr = e.err;
          holdChk = 1;
        end
      end
    end
  end

  task automatic waitIdle(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(posedge CLK);
      if (rspQ.size() == 0 && !busy &&
          mq[0].size() == 0 && mq[1].size() == 0 &&
          mq[2].size() == 0 && mq[3].size() == 0) return;
    end
    tests++;
    fails++;
    $display("FAIL idle_timeout: still busy after %0d cycles, required idle", budget);
  endtask

  initial begin
    int seen;
    int expOrder[5];
    expOrder = '{0, 1, 2, 3, 0};

    // Reset values
    #12;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_nco_ctl", bus.nco_ctl, 0);
    check("rst_freq_mod", bus.nco_freq_mod, 0);
    check("rst_pha_mod", bus.nco_pha_mod, 0);
    check("rst_busy", busy, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (2) @(posedge CLK);

    // Round robin with all four requesters held
    grantLog.delete();
    grantIdxLog.delete();
    issue(0, 2'd1, $urandom); issue(1, 2'd1, $urandom);
    issue(2, 2'd1, $urandom); issue(3, 2'd1, $urandom);
    issue(0, 2'd1, $urandom);
    waitIdle(200);
    check("rr_grants", grantIdxLog.size(), 5);
    for (int k = 0; k < 5 && k < grantIdxLog.size(); k++)
      check("rr_order", grantIdxLog[k], expOrder[k]);
    for (int k = 1; k < grantLog.size(); k++)
      check("rr_spacing", 64'(grantLog[k] - grantLog[k-1]), 5);

    // Single SET_FREQ
    @(posedge CLK);
    issue(0, 2'd0, 32'h028F5C28);
    waitIdle(100);
    check("nco_freq_applied", ncoFreq, 32'h028F5C28);

    // LOAD then READ phase
    @(posedge CLK);
    issue(1, 2'd2, 32'h12345678);
    waitIdle(100);
    @(posedge CLK);
    issue(2, 2'd3, $urandom);
    waitIdle(100);
    check("read_phase", bus.rsp_data, 32'h12345678);

    // Randomised traffic, requests also arriving while busy
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK);
      for (int i = 0; i < NR; i++)
        if ($urandom_range(0, 2) == 0) issue(i, 2'($urandom_range(0, 3)), $urandom);
      repeat ($urandom_range(0, 6)) @(posedge CLK);
    end
    waitIdle(3000);

    // Timeout waiting for ACK, then a normal command
    mode = 1;
    @(posedge CLK);
    issue(0, 2'd0, $urandom);
    waitIdle(TO + 50);
    check("ack_timeout_err_cnt", err_cnt, 1);
    mode = 0;
    @(posedge CLK);
    issue(1, 2'd3, $urandom);
    waitIdle(100);

    // Timeout waiting for DONE
    mode = 2;
    @(posedge CLK);
    issue(3, 2'd1, $urandom);
    waitIdle(TO + 50);
    check("done_timeout_err_cnt", err_cnt, 2);

    // Saturation of the timeout counter
    mode = 1;
    @(posedge CLK);
    for (int k = 0; k < 300; k++) issue(k % NR, 2'($urandom_range(0, 3)), $urandom);
    waitIdle(300 * (TO + 4) + 100);
    mode = 0;
    @(posedge CLK);
    issue(2, 2'd2, $urandom);
    waitIdle(100);
    check("err_cnt_saturated", err_cnt, 255);

    // Reset in the middle of a LOAD_PHASE
    mode = 1;
    @(posedge CLK);
    issue(1, 2'd2, $urandom);
    for (int n = 0; n < 50 && bus.nco_ctl != 4'b0100; n++) @(negedge CLK);
    check("load_ctl_seen", bus.nco_ctl, 4'b0100);
    @(posedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    check("mid_rst_ctl", bus.nco_ctl, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    check("mid_rst_pha_mod", bus.nco_pha_mod, 0);
    rspQ.delete();
    for (int i = 0; i < NR; i++) begin
      mq[i].delete();
      dq[i].delete();
    end
    mRr = 0; mErr = 0; mFreqPin = '0; mPhaPin = '0;
    mode = 0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    seen = rspSeen;
    repeat (10) @(posedge CLK);
    check("no_rsp_after_rst", rspSeen, seen);
    issue(3, 2'd0, $urandom);
    issue(0, 2'd3, $urandom);
    waitIdle(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
